// File: rtl/demux_1x2_stream_pkg.sv
// Shared constants and helpers for the 1-to-2 stream demultiplexer.
package demux_1x2_stream_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FIFO_DEPTH = 2;
  localparam logic [1:0] FULL_COUNT = 2'd2;

  // Channel identifiers for the select bit
  typedef enum logic [0:0] {
    CH0 = 1'b0,
    CH1 = 1'b1
  } channel_e;

  // True when the select value addresses the given channel
  function automatic logic sel_hits(input logic [0:0] sel, input channel_e ch);
    return sel == ch;
  endfunction

endpackage

// File: rtl/demux_1x2_stream_fifo2.sv
// Two-entry synchronous FIFO used as the per-channel buffer.
// While empty, head keeps showing the most recently popped word.
module demux_1x2_stream_fifo2
  import demux_1x2_stream_pkg::*;
#(
  parameter int W     = DATA_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] last_pop;
  logic         wptr;
  logic         rptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage, pointers, count and last-popped word; all cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      last_pop <= '0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_data;
        wptr      <= ~wptr;
      end
      if (do_pop) begin
        last_pop <= mem[rptr];
        rptr     <= ~rptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head word: live entry when non-empty, otherwise the last word handed out
  always_comb begin
    head = last_pop;
    if (!empty) begin
      head = mem[rptr];
    end
  end

endmodule

// File: rtl/demux_1x2_stream.sv
// Buffered 1-to-2 stream demultiplexer: each input word is steered by its
// select bit into one of two independent 2-entry channel FIFOs.
module demux_1x2_stream
  import demux_1x2_stream_pkg::*;
#(
  parameter int DATA_WIDTH = demux_1x2_stream_pkg::DATA_WIDTH,
  parameter int SEL_WIDTH  = 1,
  parameter int DEPTH      = FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [SEL_WIDTH-1:0]  in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out0_data,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [DATA_WIDTH-1:0] out1_data,
  output logic                  out1_valid,
  input  logic                  out1_ready
);

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;
  logic accept;

  // in_ready only looks at the fullness of the addressed channel, never at consumer ready
  always_comb begin
    in_ready = !full0;
    if (sel_hits(in_sel, CH1)) begin
      in_ready = !full1;
    end
  end

  // Select decode: a handshake writes only to the addressed channel
  always_comb begin
    accept = in_valid && in_ready;
    push0  = accept && sel_hits(in_sel, CH0);
    push1  = accept && sel_hits(in_sel, CH1);
  end

  assign out0_valid = !empty0;
  assign out1_valid = !empty1;

  demux_1x2_stream_fifo2 #(
    .W     (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_ch0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (in_data),
    .pop       (out0_ready),
    .full      (full0),
    .empty     (empty0),
    .head      (out0_data)
  );

  demux_1x2_stream_fifo2 #(
    .W     (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_ch1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (in_data),
    .pop       (out1_ready),
    .full      (full1),
    .empty     (empty1),
    .head      (out1_data)
  );

endmodule

// File: tb/tb_demux_1x2_stream.sv
// Self-checking bench for demux_1x2_stream: directed scenarios with literal
// expectations plus randomized traffic against a queue-based channel model.
module tb_demux_1x2_stream;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic [0:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;

  int checks;
  int errors;

  // Reference model: one queue per channel plus the last word each consumer took
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] last0;
  logic [15:0] last1;

  demux_1x2_stream dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input logic sel);
    return sel ? q1.size() : q0.size();
  endfunction

  // Compare every DUT output against what the model says it must be right now
  task automatic checkOutput();
    chk("in_ready",   {31'd0, in_ready},   {31'd0, (qsize(in_sel) != 2)});
    chk("out0_valid", {31'd0, out0_valid}, {31'd0, (q0.size() != 0)});
    chk("out1_valid", {31'd0, out1_valid}, {31'd0, (q1.size() != 0)});
    chk("out0_data",  {16'd0, out0_data},  {16'd0, (q0.size() != 0) ? q0[0] : last0});
    chk("out1_data",  {16'd0, out1_data},  {16'd0, (q1.size() != 0) ? q1[0] : last1});
  endtask

  function automatic void modelReset();
    q0.delete();
    q1.delete();
    last0 = 16'h0;
    last1 = 16'h0;
  endfunction

  // Drive one cycle of inputs (called just after a falling edge), check, then advance the model across the rising edge
  task automatic applyStimulus(input logic v, input logic sel, input logic [15:0] d,
                               input logic r0, input logic r1);
    logic acc, p0, p1;
    in_valid   = v;
    in_sel     = sel;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    checkOutput();
    acc = v && (qsize(sel) != 2);
    p0  = r0 && (q0.size() != 0);
    p1  = r1 && (q1.size() != 0);
    @(posedge clk);
    if (p0) last0 = q0.pop_front();
    if (p1) last1 = q1.pop_front();
    if (acc) begin
      if (sel) q1.push_back(d);
      else     q0.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    logic        pend_v;
    logic        pend_sel;
    logic [15:0] pend_d;
    checks = 0;
    errors = 0;
    modelReset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_sel = 1'b0; in_data = 16'h0;
    out0_ready = 1'b0; out1_ready = 1'b0;

    // Reset then idle
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    chk("rst_out0_data", {16'd0, out0_data}, 32'd0);
    chk("rst_out1_data", {16'd0, out1_data}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

    // Single route to channel 0
    applyStimulus(1'b1, 1'b0, 16'hA5A5, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    chk("route_out0_valid", {31'd0, out0_valid}, 32'd1);
    chk("route_out0_data", {16'd0, out0_data}, 32'h0000A5A5);
    chk("route_out1_valid", {31'd0, out1_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    #1;
    chk("route_popped_valid", {31'd0, out0_valid}, 32'd0);
    chk("route_hold_data", {16'd0, out0_data}, 32'h0000A5A5);

    // Backpressure on channel 0 must not block channel 1
    applyStimulus(1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0002, 1'b0, 1'b0);
    in_data = 16'h0003;
    #1;
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0003, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
    in_sel = 1'b1;
    #1;
    chk("bp_ch1_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b1, 1'b1, 16'h0004, 1'b0, 1'b0);
    #1;
    chk("bp_out1_data", {16'd0, out1_data}, 32'h00000004);
    chk("bp_out0_head", {16'd0, out0_data}, 32'h00000001);
    repeat (3) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

    // Full-rate alternating stream with both consumers always ready
    for (int i = 0; i < 16; i++) begin
      in_sel = i[0];
      #1;
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      applyStimulus(1'b1, i[0], 16'h0010 + 16'(i), 1'b1, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    #1;
    chk("stream_last0", {16'd0, out0_data}, 32'h0000001E);
    chk("stream_last1", {16'd0, out1_data}, 32'h0000001F);

    // Simultaneous push and pop on channel 1 at count 1
    applyStimulus(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h2222, 1'b0, 1'b1);
    in_valid = 1'b0;
    out1_ready = 1'b0;
    #1;
    chk("pp_out1_data", {16'd0, out1_data}, 32'h00002222);
    chk("pp_out1_valid", {31'd0, out1_valid}, 32'd1);
    chk("pp_not_full", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b0, 1'b1, 16'h0, 1'b0, 1'b1);

    // Fill both channels, then reset asynchronously between edges
    applyStimulus(1'b1, 1'b0, 16'hAAA1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'hAAA2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hBBB1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hBBB2, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    chk("midrst_out0_valid", {31'd0, out0_valid}, 32'd0);
    chk("midrst_out1_valid", {31'd0, out1_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out1_data", {16'd0, out1_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

    // Randomized traffic; a stalled word is held stable until accepted
    pend_v = 1'b0;
    pend_sel = 1'b0;
    pend_d = 16'h0;
    for (int i = 0; i < 400; i++) begin
      logic v, s, r0, r1;
      logic [15:0] d;
      if (pend_v) begin
        v = 1'b1; s = pend_sel; d = pend_d;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        s = 1'($urandom_range(0, 1));
        d = 16'($urandom);
      end
      r0 = ($urandom_range(0, 2) != 0);
      r1 = ($urandom_range(0, 3) == 0);
      pend_v   = v && (qsize(s) == 2);
      pend_sel = s;
      pend_d   = d;
      applyStimulus(v, s, d, r0, r1);
    end
    repeat (4) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
